ysyx_24110015_axi_arbiter: RTL and testbench

Two-master to one-slave AXI4 arbiter placed directly downstream of the instruction fetch unit (M0) and the load/store unit (M1). It forwards exactly one whole transaction at a time to the shared memory-side AXI port and routes responses back to the owning master. It also supports single-beat and INCR-burst reads, such as SDRAM cache-line refills.

---
 rtl/ysyx_24110015_axi_pkg.sv | 36 +++
 rtl/ysyx_24110015_axi_if.sv | 57 +++++
 rtl/ysyx_24110015_rr_picker.sv | 32 +++
 rtl/ysyx_24110015_axi_arbiter.sv | 150 +++++++++++++++
 tb/tb_ysyx_24110015_axi_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_24110015_axi_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_axi_pkg
// Shared definitions for the two-master AXI arbiter: arbiter state encoding,
// master indices, AXI burst/response encodings and a small helper that maps a
// granted master plus its request type onto the owning state.
// ----------------------------------------------------------------------------
package ysyx_24110015_axi_pkg;

    // Master indices: the IFU is always port 0, the LSU always port 1.
    localparam int IFU_ID = 0;
    localparam int LSU_ID = 1;

    // AXI burst type encodings.
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // AXI response encodings.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        WR0  = 3'd3,
        WR1  = 3'd4
    } arb_state_t;

    // A write request outranks a read request from the same master.
    function automatic arb_state_t grant_state(input logic idx, input logic is_wr);
        if (is_wr) return idx ? WR1 : WR0;
        return idx ? RD1 : RD0;
    endfunction

endpackage

// File: rtl/ysyx_24110015_axi_if.sv
// ----------------------------------------------------------------------------
// axi_if
// AXI4 bundle (32-bit address/data, 4-bit IDs) with all five channels.
// modport master : drives ar/aw/w payload+valid and rready/bready.
// modport slave  : drives arready/awready/wready and the r/b payload+valid.
// ----------------------------------------------------------------------------
interface axi_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;

    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
               awvalid, awaddr, awid, awlen, awsize, awburst,
               wvalid, wdata, wstrb, wlast, bready,
        input  arready, rvalid, rdata, rresp, rlast, rid,
               awready, wready, bvalid, bresp, bid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
               awvalid, awaddr, awid, awlen, awsize, awburst,
               wvalid, wdata, wstrb, wlast, bready,
        output arready, rvalid, rdata, rresp, rlast, rid,
               awready, wready, bvalid, bresp, bid
    );
endinterface

// File: rtl/ysyx_24110015_rr_picker.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_rr_picker
// Stateless 2-way round-robin picker.
//   req[1:0]   : request per master
//   last_grant : index of the master granted most recently
//   grant[1:0] : one-hot grant (all zero when nobody requests)
// On a tie the master that was not granted last wins.
// ----------------------------------------------------------------------------
module ysyx_24110015_rr_picker
    import ysyx_24110015_axi_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant[IFU_ID] = 1'b1;
            2'b10:   grant[LSU_ID] = 1'b1;
            2'b11: begin
                if (last_grant) grant[IFU_ID] = 1'b1;
                else            grant[LSU_ID] = 1'b1;
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ysyx_24110015_axi_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_24110015_axi_arbiter
// Two-master (M0 = IFU, M1 = LSU) to one-slave AXI4 arbiter. One whole
// transaction is forwarded at a time; the grant is decided only in IDLE and
// held until the read rlast handshake or the write b handshake.
//   clk, rst  : clock, asynchronous active-high reset
//   m0, m1    : master-facing AXI ports (slave modport)
//   s         : memory-facing AXI port (master modport)
//   burst_err : sticky, set when rlast arrives on a beat other than arlen+1
// ----------------------------------------------------------------------------
module ysyx_24110015_axi_arbiter
    import ysyx_24110015_axi_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int BEAT_CNT_W  = 8
) (
    input  logic  clk,
    input  logic  rst,
    axi_if.slave  m0,
    axi_if.slave  m1,
    axi_if.master s,
    output logic  burst_err
);

    if (NUM_MASTERS != 2) begin : g_bad_cfg
        $error("ysyx_24110015_axi_arbiter supports exactly two masters");
    end

    arb_state_t state, state_nxt;
    logic       last_grant;
    logic [1:0] req, grant;

    logic [BEAT_CNT_W-1:0] beat_cnt;
    logic [BEAT_CNT_W-1:0] arlen_q;
    logic [BEAT_CNT_W:0]   beats_seen, beats_expected;
    logic                  r_hs, rd_enter;

    logic m0_rd, m1_rd, m0_wr, m1_wr;

    assign req[IFU_ID] = m0.arvalid | m0.awvalid;
    assign req[LSU_ID] = m1.arvalid | m1.awvalid;

    ysyx_24110015_rr_picker u_picker (
        .req        (req),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant[IFU_ID])      state_nxt = grant_state(1'b0, m0.awvalid);
                else if (grant[LSU_ID]) state_nxt = grant_state(1'b1, m1.awvalid);
            end
            RD0, RD1: if (s.rvalid && s.rready && s.rlast) state_nxt = IDLE;
            WR0, WR1: if (s.bvalid && s.bready) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;   // M0 wins the first tie after reset
        end else begin
            state <= state_nxt;
            if (state == IDLE && grant != 2'b00) last_grant <= grant[LSU_ID];
        end
    end

    // Beat accounting for burst reads.
    assign r_hs     = s.rvalid & s.rready;
    assign rd_enter = (state == IDLE) && (state_nxt == RD0 || state_nxt == RD1);

    // One bit wider so arlen = 255 (256 beats) compares without wrap.
    assign beats_seen     = {1'b0, beat_cnt} + (BEAT_CNT_W+1)'(1);
    assign beats_expected = {1'b0, arlen_q}  + (BEAT_CNT_W+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt  <= '0;
            arlen_q   <= '0;
            burst_err <= 1'b0;
        end else begin
            if (rd_enter)  beat_cnt <= '0;
            else if (r_hs) beat_cnt <= beat_cnt + 1'b1;

            if (s.arvalid && s.arready) arlen_q <= BEAT_CNT_W'(s.arlen);

            if (r_hs && s.rlast && beats_seen != beats_expected) burst_err <= 1'b1;
        end
    end

    // Ownership decode: at most one of these is high, none in IDLE.
    assign m0_rd = (state == RD0);
    assign m1_rd = (state == RD1);
    assign m0_wr = (state == WR0);
    assign m1_wr = (state == WR1);

    // Memory side: owner's signals pass through, everything else is zero.
    assign s.arvalid = (m0_rd & m0.arvalid) | (m1_rd & m1.arvalid);
    assign s.araddr  = m0_rd ? m0.araddr  : (m1_rd ? m1.araddr  : '0);
    assign s.arid    = m0_rd ? m0.arid    : (m1_rd ? m1.arid    : '0);
    assign s.arlen   = m0_rd ? m0.arlen   : (m1_rd ? m1.arlen   : '0);
    assign s.arsize  = m0_rd ? m0.arsize  : (m1_rd ? m1.arsize  : '0);
    assign s.arburst = m0_rd ? m0.arburst : (m1_rd ? m1.arburst : '0);
    assign s.rready  = (m0_rd & m0.rready) | (m1_rd & m1.rready);

    assign s.awvalid = (m0_wr & m0.awvalid) | (m1_wr & m1.awvalid);
    assign s.awaddr  = m0_wr ? m0.awaddr  : (m1_wr ? m1.awaddr  : '0);
    assign s.awid    = m0_wr ? m0.awid    : (m1_wr ? m1.awid    : '0);
    assign s.awlen   = m0_wr ? m0.awlen   : (m1_wr ? m1.awlen   : '0);
    assign s.awsize  = m0_wr ? m0.awsize  : (m1_wr ? m1.awsize  : '0);
    assign s.awburst = m0_wr ? m0.awburst : (m1_wr ? m1.awburst : '0);
    assign s.wvalid  = (m0_wr & m0.wvalid) | (m1_wr & m1.wvalid);
    assign s.wdata   = m0_wr ? m0.wdata   : (m1_wr ? m1.wdata   : '0);
    assign s.wstrb   = m0_wr ? m0.wstrb   : (m1_wr ? m1.wstrb   : '0);
    assign s.wlast   = (m0_wr & m0.wlast) | (m1_wr & m1.wlast);
    assign s.bready  = (m0_wr & m0.bready) | (m1_wr & m1.bready);

    // Master side: a master that does not own the bus sees an idle slave,
    // so its pending request simply waits.
    assign m0.arready = m0_rd & s.arready;
    assign m0.rvalid  = m0_rd & s.rvalid;
    assign m0.rdata   = m0_rd ? s.rdata : '0;
    assign m0.rresp   = m0_rd ? s.rresp : '0;
    assign m0.rlast   = m0_rd & s.rlast;
    assign m0.rid     = m0_rd ? s.rid   : '0;
    assign m0.awready = m0_wr & s.awready;
    assign m0.wready  = m0_wr & s.wready;
    assign m0.bvalid  = m0_wr & s.bvalid;
    assign m0.bresp   = m0_wr ? s.bresp : '0;
    assign m0.bid     = m0_wr ? s.bid   : '0;

    assign m1.arready = m1_rd & s.arready;
    assign m1.rvalid  = m1_rd & s.rvalid;
    assign m1.rdata   = m1_rd ? s.rdata : '0;
    assign m1.rresp   = m1_rd ? s.rresp : '0;
    assign m1.rlast   = m1_rd & s.rlast;
    assign m1.rid     = m1_rd ? s.rid   : '0;
    assign m1.awready = m1_wr & s.awready;
    assign m1.wready  = m1_wr & s.wready;
    assign m1.bvalid  = m1_wr & s.bvalid;
    assign m1.bresp   = m1_wr ? s.bresp : '0;
    assign m1.bid     = m1_wr ? s.bid   : '0;

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ysyx_24110015_axi_arbiter
// Self-checking bench: the bench plays both masters and the slave. A table of
// request patterns covers grant selection; hand-written sequences cover
// latency, back-to-back hand-over, bursts, malformed bursts, write-before-read
// and asynchronous reset in the middle of a burst.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge or 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_ysyx_24110015_axi_arbiter;
    import ysyx_24110015_axi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic burst_err;

    always #5 clk = ~clk;

    axi_if m0_if ();
    axi_if m1_if ();
    axi_if s_if ();

    ysyx_24110015_axi_arbiter #(
        .NUM_MASTERS (2),
        .BEAT_CNT_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .burst_err (burst_err)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    string cur_test = "init";

    localparam logic [31:0] M0_AR = 32'h1000_0000;
    localparam logic [31:0] M0_AW = 32'h1000_0100;
    localparam logic [31:0] M1_AR = 32'h2000_0000;
    localparam logic [31:0] M1_AW = 32'h2000_0100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL [%s] %s: got 0x%0h, expected 0x%0h", cur_test, name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic get_arready(input int m);
        return (m == 0) ? m0_if.arready : m1_if.arready;
    endfunction
    function automatic logic get_awready(input int m);
        return (m == 0) ? m0_if.awready : m1_if.awready;
    endfunction
    function automatic logic get_rvalid(input int m);
        return (m == 0) ? m0_if.rvalid : m1_if.rvalid;
    endfunction
    function automatic logic get_rlast(input int m);
        return (m == 0) ? m0_if.rlast : m1_if.rlast;
    endfunction
    function automatic logic [31:0] get_rdata(input int m);
        return (m == 0) ? m0_if.rdata : m1_if.rdata;
    endfunction
    function automatic logic [1:0] get_rresp(input int m);
        return (m == 0) ? m0_if.rresp : m1_if.rresp;
    endfunction
    function automatic logic get_bvalid(input int m);
        return (m == 0) ? m0_if.bvalid : m1_if.bvalid;
    endfunction
    function automatic logic [1:0] get_bresp(input int m);
        return (m == 0) ? m0_if.bresp : m1_if.bresp;
    endfunction

    task automatic clear_inputs();
        m0_if.arvalid = 0; m0_if.araddr = '0; m0_if.arid = '0; m0_if.arlen = '0;
        m0_if.arsize = '0; m0_if.arburst = '0; m0_if.rready = 1;
        m0_if.awvalid = 0; m0_if.awaddr = '0; m0_if.awid = '0; m0_if.awlen = '0;
        m0_if.awsize = '0; m0_if.awburst = '0;
        m0_if.wvalid = 0; m0_if.wdata = '0; m0_if.wstrb = '0; m0_if.wlast = 0; m0_if.bready = 1;
        m1_if.arvalid = 0; m1_if.araddr = '0; m1_if.arid = '0; m1_if.arlen = '0;
        m1_if.arsize = '0; m1_if.arburst = '0; m1_if.rready = 1;
        m1_if.awvalid = 0; m1_if.awaddr = '0; m1_if.awid = '0; m1_if.awlen = '0;
        m1_if.awsize = '0; m1_if.awburst = '0;
        m1_if.wvalid = 0; m1_if.wdata = '0; m1_if.wstrb = '0; m1_if.wlast = 0; m1_if.bready = 1;
        s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = '0; s_if.rresp = '0;
        s_if.rlast = 0; s_if.rid = '0;
        s_if.awready = 0; s_if.wready = 0; s_if.bvalid = 0; s_if.bresp = '0; s_if.bid = '0;
    endtask

    task automatic m_read(input int m, input logic [31:0] addr, input logic [7:0] len);
        if (m == 0) begin
            m0_if.arvalid = 1; m0_if.araddr = addr; m0_if.arid = 4'h0;
            m0_if.arlen = len; m0_if.arsize = 3'd2; m0_if.arburst = BURST_INCR;
        end else begin
            m1_if.arvalid = 1; m1_if.araddr = addr; m1_if.arid = 4'h1;
            m1_if.arlen = len; m1_if.arsize = 3'd2; m1_if.arburst = BURST_INCR;
        end
    endtask

    task automatic m_write(input int m, input logic [31:0] addr, input logic [31:0] data);
        if (m == 0) begin
            m0_if.awvalid = 1; m0_if.awaddr = addr; m0_if.awid = 4'h0; m0_if.awlen = 0;
            m0_if.awsize = 3'd2; m0_if.awburst = BURST_INCR;
            m0_if.wvalid = 1; m0_if.wdata = data; m0_if.wstrb = 4'hf; m0_if.wlast = 1;
        end else begin
            m1_if.awvalid = 1; m1_if.awaddr = addr; m1_if.awid = 4'h1; m1_if.awlen = 0;
            m1_if.awsize = 3'd2; m1_if.awburst = BURST_INCR;
            m1_if.wvalid = 1; m1_if.wdata = data; m1_if.wstrb = 4'hf; m1_if.wlast = 1;
        end
    endtask

    task automatic m_drop_ar(input int m);
        if (m == 0) m0_if.arvalid = 0; else m1_if.arvalid = 0;
    endtask

    task automatic m_drop_aw(input int m);
        if (m == 0) begin m0_if.awvalid = 0; m0_if.wvalid = 0; end
        else begin m1_if.awvalid = 0; m1_if.wvalid = 0; end
    endtask

    // Slave side of a read. lat = cycles waited until s.arvalid was seen.
    // Returns one time unit after the rlast handshake edge (FSM back in IDLE).
    task automatic serve_read(input int m, input int nbeats, input int last_beat,
                              input logic [7:0] bubbles, input logic [31:0] exp_addr,
                              input logic [31:0] base, input logic [1:0] resp,
                              output int lat);
        lat = 0;
        s_if.arready = 1;
        while (!s_if.arvalid && lat < 16) begin tick(); lat++; end
        check("s.arvalid forwarded", s_if.arvalid, 1);
        check("s.araddr", s_if.araddr, exp_addr);
        check("other arready", get_arready(1 - m), 0);
        tick();
        s_if.arready = 0;
        m_drop_ar(m);
        for (int b = 0; b < nbeats; b++) begin
            if (bubbles[b]) begin
                s_if.rvalid = 0;
                @(negedge clk);
                check("bubble rvalid", get_rvalid(m), 0);
                tick();
            end
            s_if.rvalid = 1;
            s_if.rdata  = base + b;
            s_if.rresp  = resp;
            s_if.rlast  = (b == last_beat);
            @(negedge clk);
            check("rdata", get_rdata(m), base + b);
            check("rresp", get_rresp(m), resp);
            check("rlast", get_rlast(m), (b == last_beat));
            check("other rvalid", get_rvalid(1 - m), 0);
            check("no second s.arvalid", s_if.arvalid, 0);
            tick();
            if (b == last_beat) break;
        end
        s_if.rvalid = 0;
        s_if.rlast  = 0;
    endtask

    // Slave side of a single-beat write; returns one time unit after the b
    // handshake edge.
    task automatic serve_write(input int m, input logic [31:0] exp_addr,
                               input logic [31:0] exp_data, input logic [1:0] resp,
                               output int lat);
        lat = 0;
        s_if.awready = 1;
        s_if.wready  = 1;
        while (!s_if.awvalid && lat < 16) begin tick(); lat++; end
        check("s.awvalid forwarded", s_if.awvalid, 1);
        check("s.awaddr", s_if.awaddr, exp_addr);
        check("s.wvalid", s_if.wvalid, 1);
        check("s.wdata", s_if.wdata, exp_data);
        check("s.arvalid during write", s_if.arvalid, 0);
        check("other awready", get_awready(1 - m), 0);
        tick();
        s_if.awready = 0;
        s_if.wready  = 0;
        m_drop_aw(m);
        s_if.bvalid = 1;
        s_if.bresp  = resp;
        @(negedge clk);
        check("bvalid", get_bvalid(m), 1);
        check("bresp", get_bresp(m), resp);
        check("other bvalid", get_bvalid(1 - m), 0);
        tick();
        s_if.bvalid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    typedef struct packed {
        logic m0_ar;
        logic m0_aw;
        logic m1_ar;
        logic m1_aw;
        logic exp_none;
        logic exp_m;
        logic exp_wr;
    } vec_t;

    localparam int NV = 10;
    vec_t vec [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [31:0] addr, data;

        // Grant table. last_grant starts at 1 after reset; the comment is the
        // last_grant value after each row.
        vec[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // M0 RD   lg=0
        vec[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1}; // M1 WR   lg=1
        vec[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // M0 RD   lg=0
        vec[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}; // M0 WR   lg=0
        vec[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // M1 RD   lg=1
        vec[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}; // M0 WR   lg=0
        vec[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1}; // M1 WR   lg=1
        vec[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // none    lg=1
        vec[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}; // M1 RD   lg=1
        vec[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // M0 RD   lg=0

        // ---------------- reset state ----------------
        cur_test = "reset";
        rst = 1;
        clear_inputs();
        @(negedge clk);
        check("burst_err", burst_err, 0);
        check("s.arvalid", s_if.arvalid, 0);
        check("s.awvalid", s_if.awvalid, 0);
        check("s.wvalid", s_if.wvalid, 0);
        check("s.rready", s_if.rready, 0);
        check("s.bready", s_if.bready, 0);
        check("s.araddr", s_if.araddr, 0);
        check("m0.arready", m0_if.arready, 0);
        do_reset();

        // ---------------- grant table ----------------
        for (int i = 0; i < NV; i++) begin
            cur_test = $sformatf("table v%0d", i);
            if (vec[i].m0_ar) m_read(0, M0_AR, 8'd0);
            if (vec[i].m0_aw) m_write(0, M0_AW, 32'h0A0A_0000);
            if (vec[i].m1_ar) m_read(1, M1_AR, 8'd0);
            if (vec[i].m1_aw) m_write(1, M1_AW, 32'h0B0B_0000);
            @(negedge clk);
            check("IDLE holds s quiet", {30'd0, s_if.arvalid, s_if.awvalid}, 0);
            tick();
            if (vec[i].exp_none) begin
                check("no grant", {29'd0, s_if.arvalid, s_if.awvalid, s_if.wvalid}, 0);
            end else if (vec[i].exp_wr) begin
                addr = vec[i].exp_m ? M1_AW : M0_AW;
                data = vec[i].exp_m ? 32'h0B0B_0000 : 32'h0A0A_0000;
                serve_write(int'(vec[i].exp_m), addr, data, RESP_OKAY, lat);
                check("write grant latency", lat, 0);
            end else begin
                addr = vec[i].exp_m ? M1_AR : M0_AR;
                serve_read(int'(vec[i].exp_m), 1, 0, 8'h00, addr, 32'hC000_0000 + i,
                           RESP_OKAY, lat);
                check("read grant latency", lat, 0);
            end
            clear_inputs();
            tick();
        end

        // ---------------- IFU single read ----------------
        cur_test = "ifu single";
        do_reset();
        m_read(0, 32'h3000_0000, 8'd0);
        @(negedge clk);
        check("s.arvalid same cycle", s_if.arvalid, 0);
        serve_read(0, 1, 0, 8'h00, 32'h3000_0000, 32'hDEAD_BEEF, RESP_OKAY, lat);
        check("ar forwarded next cycle", lat, 1);
        @(negedge clk);
        check("back in IDLE: s.rready", s_if.rready, 0);
        check("back in IDLE: s.arvalid", s_if.arvalid, 0);

        // ---------------- simultaneous m0 read / m1 write ----------------
        cur_test = "m0 rd vs m1 wr";
        do_reset();
        m_read(0, 32'h1111_0000, 8'd0);
        m_write(1, 32'h2222_0000, 32'h1234_5678);
        serve_read(0, 1, 0, 8'h00, 32'h1111_0000, 32'h0000_1111, RESP_OKAY, lat);
        check("m0 granted first", lat, 1);
        // IDLE cycle after rlast: M0 asks again, M1 still pending -> M1 wins.
        m_read(0, 32'h1111_0040, 8'd0);
        @(negedge clk);
        check("no bypass of IDLE", s_if.awvalid, 0);
        serve_write(1, 32'h2222_0000, 32'h1234_5678, RESP_OKAY, lat);
        check("m1 write 2 cycles after rlast", lat, 1);
        serve_read(0, 1, 0, 8'h00, 32'h1111_0040, 32'h0000_2222, RESP_OKAY, lat);
        check("m0 second read after m1", lat, 1);

        // ---------------- SDRAM burst with bubbles ----------------
        cur_test = "burst";
        m_read(0, 32'ha000_0010, 8'd3);
        tick();
        m_read(1, 32'h2000_0200, 8'd0);
        serve_read(0, 4, 3, 8'b0000_1010, 32'ha000_0010, 32'h5000_0000, RESP_OKAY, lat);
        check("burst grant latency", lat, 0);
        check("burst_err after good burst", burst_err, 0);
        serve_read(1, 1, 0, 8'h00, 32'h2000_0200, 32'h5100_0000, RESP_OKAY, lat);
        check("m1 waits for rlast", lat, 1);
        check("burst_err still clear", burst_err, 0);

        // ---------------- malformed burst ----------------
        cur_test = "malformed";
        m_read(0, 32'ha000_0040, 8'd3);
        serve_read(0, 4, 1, 8'h00, 32'ha000_0040, 32'h6000_0000, RESP_SLVERR, lat);
        check("burst_err set next cycle", burst_err, 1);
        @(negedge clk);
        check("IDLE after early rlast", {30'd0, s_if.arvalid, s_if.rready}, 0);
        m_read(1, 32'h2000_0300, 8'd0);
        serve_read(1, 1, 0, 8'h00, 32'h2000_0300, 32'h6100_0000, RESP_OKAY, lat);
        check("burst_err sticky", burst_err, 1);

        // ---------------- LSU aw + ar together ----------------
        cur_test = "lsu aw+ar";
        m_write(1, 32'h2000_0400, 32'h55AA_55AA);
        m_read(1, 32'h2000_0500, 8'd0);
        serve_write(1, 32'h2000_0400, 32'h55AA_55AA, RESP_SLVERR, lat);
        check("write served first", lat, 1);
        serve_read(1, 1, 0, 8'h00, 32'h2000_0500, 32'h7700_0000, RESP_OKAY, lat);
        check("read granted after b", lat, 1);
        repeat (3) tick();
        check("read not duplicated", {30'd0, s_if.arvalid, s_if.awvalid}, 0);

        // ---------------- async reset mid-burst ----------------
        cur_test = "async reset";
        m_read(0, 32'h8000_0000, 8'd3);
        s_if.arready = 1;
        tick();
        check("burst ar forwarded", s_if.arvalid, 1);
        tick();
        s_if.arready = 0;
        m_drop_ar(0);
        s_if.rvalid = 1;
        s_if.rdata  = 32'h7000_0000;
        tick();
        s_if.rdata  = 32'h7000_0001;
        @(negedge clk);
        check("rready before reset", s_if.rready, 1);
        #1 rst = 1;
        #1;
        check("s.rready drops at once", s_if.rready, 0);
        check("s.arvalid after reset", s_if.arvalid, 0);
        check("m0.rvalid after reset", m0_if.rvalid, 0);
        check("burst_err cleared", burst_err, 0);
        clear_inputs();
        @(posedge clk);
        #2 rst = 0;
        m_read(0, 32'h8000_0100, 8'd0);
        serve_read(0, 1, 0, 8'h00, 32'h8000_0100, 32'h7100_0000, RESP_OKAY, lat);
        check("post-reset grant", lat, 1);
        check("burst_err after post-reset read", burst_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
